// File: rtl/ksa_burst_accumulator_pkg.sv
// Shared types and constants for the Kogge-Stone burst accumulator.
// Optional saturation build: KSA_BURST_ACC_SAT_EN.
package ksa_burst_accumulator_pkg;

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int KSA_W = 11;
    localparam int DEF_CNT_W = 4;

    localparam logic [KSA_W-1:0] ACC_MAX = '1;
    localparam logic [DEF_CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/ksa_burst_accumulator_if.sv
// Operand and result valid/ready streams of the burst accumulator.
interface ksa_burst_accumulator_if #(
    parameter int WIDTH = 11,
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_clear;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_ovf;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_data, in_last, in_clear, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, in_clear, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, out_count
    );
endinterface

// File: rtl/ksa_burst_accumulator_adder.sv
// 11-bit Kogge-Stone parallel-prefix adder with carry-in and carry-out.
module PPA_Kogge_Stone_11bit (
    input  logic [10:0] A,
    input  logic [10:0] B,
    input  logic        cin,
    output logic [10:0] S,
    output logic        cout
);
    logic [4:0][10:0] gk;
    logic [4:0][10:0] pk;
    logic [11:0]      c;

    // Prefix levels span 1, 2, 4 and 8 bits; level 4 holds G/P of [i:0].
    always_comb begin
        gk = '0;
        pk = '0;
        gk[0] = A & B;
        pk[0] = A ^ B;
        for (int k = 1; k < 5; k++) begin
            for (int i = 0; i < 11; i++) begin
                if (i >= (1 << (k - 1))) begin
                    gk[k][i] = gk[k-1][i]
                             | (pk[k-1][i] & gk[k-1][i-(1<<(k-1))]);
                    pk[k][i] = pk[k-1][i] & pk[k-1][i-(1<<(k-1))];
                end else begin
                    gk[k][i] = gk[k-1][i];
                    pk[k][i] = pk[k-1][i];
                end
            end
        end
    end

    always_comb begin
        c = '0;
        c[0] = cin;
        for (int i = 0; i < 11; i++) begin
            c[i+1] = gk[4][i] | (pk[4][i] & cin);
        end
    end

    assign S    = pk[0] ^ c[10:0];
    assign cout = c[11];
endmodule

// File: rtl/ksa_burst_accumulator.sv
// Burst accumulator over a valid/ready stream using the 11-bit KS adder.
// Define KSA_BURST_ACC_SAT_EN to clamp stored sums at the all-ones value.
module ksa_burst_accumulator
    import ksa_burst_accumulator_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int CNT_W = 4
) (
    input logic clk,
    input logic rst_n,
    ksa_burst_accumulator_if.slave bus
);
    generate
        if (WIDTH != KSA_W) begin : g_bad_width
            $error("ksa_burst_accumulator: WIDTH must be 11");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_TOP = '1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             oovf_q, oovf_d;
    logic [CNT_W-1:0] ocnt_q, ocnt_d;

    logic [WIDTH-1:0] sum_n;
    logic             carry;
    logic             ovf_n;
    logic [WIDTH-1:0] upd;
    logic [CNT_W-1:0] cnt_inc;

    PPA_Kogge_Stone_11bit u_adder (
        .A    (acc_q),
        .B    (bus.in_data),
        .cin  (1'b0),
        .S    (sum_n),
        .cout (carry)
    );

    assign ovf_n   = ovf_q | carry;
    assign cnt_inc = (cnt_q == CNT_TOP) ? cnt_q : cnt_q + 1'b1;

`ifdef KSA_BURST_ACC_SAT_EN
    assign upd = ovf_n ? ACC_MAX : sum_n;
`else
    assign upd = sum_n;
`endif

    assign bus.in_ready  = (state_q == ACC);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_sum   = sum_q;
    assign bus.out_ovf   = oovf_q;
    assign bus.out_count = ocnt_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        oovf_d  = oovf_q;
        ocnt_d  = ocnt_q;
        unique case (state_q)
            ACC: begin
                // A clear swallows any same-cycle beat, last included.
                if (bus.in_clear) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    cnt_d = '0;
                end else if (bus.in_valid) begin
                    if (bus.in_last) begin
                        sum_d   = upd;
                        oovf_d  = ovf_n;
                        ocnt_d  = cnt_inc;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        acc_d = upd;
                        ovf_d = ovf_n;
                        cnt_d = cnt_inc;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) state_d = ACC;
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            oovf_q  <= 1'b0;
            ocnt_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            oovf_q  <= oovf_d;
            ocnt_q  <= ocnt_d;
        end
    end
endmodule
